issue_queue: RTL

Circular buffer of decoded instructions between the decoder and the read-operand stage. It accepts 0–2 decoded instructions per cycle and presents 0–2 of them per cycle as the `id_a_*` / `id_b_*` pair. It applies the dual-issue pairing rules, so the read-operand stage never receives an intra-pair hazard. It also decouples decoder throughput from read-operand stalls.

---
 rtl/issue_queue_pkg.sv | 49 ++++
 rtl/issue_queue_dual_issue_check.sv | 31 +++
 rtl/issue_queue.sv | 92 +++++++++
 3 files changed

// File: rtl/issue_queue_pkg.sv
// Shared decoder/issue definitions: decoded instruction record and its field enums.
package issue_queue_pkg;

    typedef enum logic [4:0] {
        OpNop, OpAdd, OpSub, OpOr, OpAnd, OpXor, OpSll, OpLdW, OpStW,
        OpBeq, OpBne, OpJirl, OpCsrrd, OpErtn, OpSyscall
    } opcode_t;

    typedef enum logic [1:0] {MemNone, MemLoad, MemStore} mem_type_t;

    typedef enum logic [1:0] {SizeB, SizeH, SizeW} mem_size_t;

    typedef enum logic [2:0] {
        SpecNone, SpecCsr, SpecErtn, SpecSyscall, SpecBreak, SpecIdle
    } spec_opcode_t;

    typedef enum logic [3:0] {ExcNone, ExcAdef, ExcIne, ExcIpe, ExcPif} exception_t;

    localparam logic [4:0] RegZero = 5'd0;

`ifdef DIFFTEST_EN
    typedef struct packed {
        logic [31:0] instr;
        logic        is_cnt;
    } difftest_rec_t;
`endif

    typedef struct packed {
        logic [31:0]  pc;
        logic         have_exception;
        exception_t   exc_code;
        opcode_t      opcode;
        logic [4:0]   src1;
        logic [4:0]   src2;
        logic         src2_is_imm;
        logic [31:0]  imm;
        logic [4:0]   dest;
        logic         is_branch;
        logic         pred_taken;
        logic [31:0]  pred_target;
        mem_type_t    mem_type;
        mem_size_t    mem_size;
        spec_opcode_t spec_op;
`ifdef DIFFTEST_EN
        difftest_rec_t difftest;
`endif
    } decoded_inst_t;

endpackage

// File: rtl/issue_queue_dual_issue_check.sv
// Pairing legality for two adjacent queue entries (a is older than b).
module dual_issue_check
    import issue_queue_pkg::*;
(
    input  decoded_inst_t i_inst_a,
    input  decoded_inst_t i_inst_b,
    output logic          o_pair_ok
);

    logic w_raw;
    logic w_mem;
    logic w_spec;
    logic w_exc;
    logic w_br;
    logic w_unused;

    always_comb begin
        // src2 doubles as store data, so it counts unless it is an immediate slot
        w_raw = (i_inst_a.dest != RegZero) &&
                ((i_inst_a.dest == i_inst_b.src1) ||
                 ((i_inst_a.dest == i_inst_b.src2) && !i_inst_b.src2_is_imm));
        w_mem  = (i_inst_a.mem_type != MemNone) && (i_inst_b.mem_type != MemNone);
        w_spec = (i_inst_a.spec_op != SpecNone) || (i_inst_b.spec_op != SpecNone);
        w_exc  = i_inst_a.have_exception;
        w_br   = i_inst_a.is_branch && i_inst_b.is_branch;
        o_pair_ok = !(w_raw || w_mem || w_spec || w_exc || w_br);
    end

    assign w_unused = ^{i_inst_a, i_inst_b};

endmodule

// File: rtl/issue_queue.sv
// Circular decoded-instruction buffer between decode and read-operand, 2 in / 2 out.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          ro_stall,
    input  logic          dec_a_valid,
    input  decoded_inst_t dec_a_inst,
    input  logic          dec_b_valid,
    input  decoded_inst_t dec_b_inst,
    output logic          iq_allowin,
    output logic          id_a_ready,
    output decoded_inst_t id_a_inst,
    output logic          id_b_ready,
    output decoded_inst_t id_b_inst
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] r_head;
    logic [PtrW-1:0] r_tail;
    logic [CntW-1:0] r_count;
    decoded_inst_t   r_entries [DEPTH];

    logic [PtrW-1:0] w_head_p1;
    logic [PtrW-1:0] w_tail_p1;
    logic [PtrW-1:0] w_tail_next;
    logic [PtrW-1:0] w_head_next;
    logic [CntW-1:0] w_count_next;
    logic            w_pair_ok;
    logic            w_push_a;
    logic            w_push_b;
    logic            w_pop_a;
    logic            w_pop_b;

    // Pointers are log2(DEPTH) wide, so +1 wraps modulo DEPTH for free
    assign w_head_p1 = r_head + PtrW'(1);
    assign w_tail_p1 = r_tail + PtrW'(1);

    assign id_a_inst = r_entries[r_head];
    assign id_b_inst = r_entries[w_head_p1];

    dual_issue_check u_dual_issue_check (
        .i_inst_a  (id_a_inst),
        .i_inst_b  (id_b_inst),
        .o_pair_ok (w_pair_ok)
    );

    always_comb begin
        iq_allowin = !reset && (r_count <= CntW'(DEPTH - 2));
        id_a_ready = !reset && !flush && (r_count >= CntW'(1));
        id_b_ready = !reset && !flush && (r_count >= CntW'(2)) && w_pair_ok;

        w_push_a = dec_a_valid && iq_allowin && !flush;
        w_push_b = dec_b_valid && iq_allowin && !flush;
        w_pop_a  = id_a_ready && !ro_stall;
        w_pop_b  = id_b_ready && !ro_stall;

        w_tail_next  = r_tail + PtrW'(w_push_a) + PtrW'(w_push_b);
        w_head_next  = r_head + PtrW'(w_pop_a) + PtrW'(w_pop_b);
        w_count_next = r_count + CntW'(w_push_a) + CntW'(w_push_b)
                     - CntW'(w_pop_a) - CntW'(w_pop_b);
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_entries[r_tail] <= dec_a_inst;
        end
        if (w_push_b) begin
            r_entries[w_tail_p1] <= dec_b_inst;
        end
    end

endmodule
